// File: rtl/input_register_if.sv
// Bundle of the producer-side handshake and CPU-side pop/result signals of
// the inbound byte buffer. The block itself uses the slave modport; the
// external producer / CPU side uses the master modport.
interface input_register_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_valid;
  logic                  ext_ready;
  logic                  read_enable;
  logic                  clear;
  logic [DATA_WIDTH-1:0] acc_value;
  logic                  acc_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  underflow;

  modport slave (
    input  ext_data, ext_valid, read_enable, clear,
    output ext_ready, acc_value, acc_valid, count, empty, full, underflow
  );

  modport master (
    output ext_data, ext_valid, read_enable, clear,
    input  ext_ready, acc_value, acc_valid, count, empty, full, underflow
  );
endinterface

// File: rtl/input_register.sv
// Inbound byte buffer: a circular FIFO filled by an external producer over a
// valid/ready handshake and drained by the CPU one byte per read strobe into
// a registered accumulator-load value.
module input_register #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                clk,
  input logic                reset,
  input_register_if.slave    bus
);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] acc_value_p1;
  logic                  vld_p1;
  logic                  underflow_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  push;
  logic                  pop;

  // full/empty come from the occupancy count so a full buffer (pointers equal)
  // is never mistaken for an empty one
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign push    = bus.ext_valid && !full_w;
  assign pop     = bus.read_enable && !empty_w;

  // Storage write; contents survive reset and clear, only pointers move
  always_ff @(posedge clk) begin
    if (!reset && !bus.clear && push) begin
      mem[wr_ptr] <= bus.ext_data;
    end
  end

  // Pointer, occupancy and status control; reset beats clear beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      vld_p1      <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      vld_p1      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      vld_p1 <= pop;
      if (bus.read_enable && empty_w) begin
        underflow_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // --- stage p1: popped byte registered toward the accumulator ---
  // Result register holds its value except on a successful pop
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_value_p1 <= '0;
    end else if (!bus.clear && pop) begin
      acc_value_p1 <= mem[rd_ptr];
    end
  end

  assign bus.ext_ready = !full_w;
  assign bus.acc_value = acc_value_p1;
  assign bus.acc_valid = vld_p1;
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_input_register.sv
// Directed bench for input_register with a queue-based reference model and
// a scoreboard of expected popped bytes.
module tb_input_register;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  input_register_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  input_register #(.DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] sb_q[$];
  logic       m_accv;
  logic [7:0] m_accval;
  logic       m_under;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // compare every output against the model; popped data via the scoreboard
  task automatic check_all();
    logic [7:0] e;
    chk("acc_valid", bus.acc_valid, m_accv);
    if (bus.acc_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("acc_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("acc_data", bus.acc_value, e);
      end
    end
    chk("acc_value", bus.acc_value, m_accval);
    chk("count", bus.count, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == 32);
    chk("ext_ready", bus.ext_ready, mq.size() != 32);
    chk("underflow", bus.underflow, m_under);
  endtask

  // drive one cycle; model predicts the edge, outputs checked #1 after it
  task automatic step(input logic v, input logic [7:0] d, input logic re, input logic clr);
    logic p_full, p_empty;
    bus.ext_valid   = v;
    bus.ext_data    = d;
    bus.read_enable = re;
    bus.clear       = clr;
    p_full  = (mq.size() == 32);
    p_empty = (mq.size() == 0);
    if (clr) begin
      mq.delete();
      m_under = 1'b0;
      m_accv  = 1'b0;
    end else begin
      if (re && !p_empty) begin
        m_accval = mq.pop_front();
        m_accv   = 1'b1;
        sb_q.push_back(m_accval);
      end else begin
        m_accv = 1'b0;
      end
      if (re && p_empty) m_under = 1'b1;
      if (v && !p_full) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    bus.ext_valid   = 1'b0;
    bus.read_enable = 1'b0;
    bus.clear       = 1'b0;
    check_all();
  endtask

  // reset with a handshake and pop strobe active to show both are dropped
  task automatic do_reset();
    reset           = 1'b1;
    bus.ext_valid   = 1'b1;
    bus.ext_data    = 8'hEE;
    bus.read_enable = 1'b1;
    bus.clear       = 1'b0;
    mq.delete();
    sb_q.delete();
    m_accv   = 1'b0;
    m_accval = 8'h00;
    m_under  = 1'b0;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.ext_valid   = 1'b0;
    bus.read_enable = 1'b0;
    check_all();
    chk("rst_acc_value", bus.acc_value, 8'h00);
    chk("rst_count", bus.count, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.ext_valid   = 1'b0;
    bus.ext_data    = 8'h00;
    bus.read_enable = 1'b0;
    bus.clear       = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // basic push of three bytes then three pops
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    chk("three_count", bus.count, 3);
    step(0, 8'h00, 1, 0);
    chk("pop1", bus.acc_value, 8'h11);
    step(0, 8'h00, 1, 0);
    chk("pop2", bus.acc_value, 8'h22);
    step(0, 8'h00, 1, 0);
    chk("pop3", bus.acc_value, 8'h33);
    chk("drained_empty", bus.empty, 1);

    // fill to full, blocked 33rd byte, pop while full, then accept
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", bus.full, 1);
    chk("fill_ready", bus.ext_ready, 0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hAA, 0, 0);
    chk("blocked_count", bus.count, 32);
    step(1, 8'hAA, 1, 0);
    chk("full_pop_val", bus.acc_value, 8'h00);
    chk("full_pop_ready", bus.ext_ready, 1);
    chk("full_pop_count", bus.count, 31);
    step(1, 8'hAA, 0, 0);
    chk("aa_accepted", bus.count, 32);
    for (int i = 0; i < 32; i++) step(0, 8'h00, 1, 0);
    chk("aa_last", bus.acc_value, 8'hAA);

    // interleaved traffic across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h40 + i), (i % 3) != 0, 0);
      chk("count_max", bus.count <= 6'd32, 1);
    end
    while (mq.size() != 0) step(0, 8'h00, 1, 0);
    chk("wrap_last", bus.acc_value, 8'h40 + 8'd39);
    chk("wrap_sb_drained", sb_q.size(), 0);

    // empty read sets sticky underflow; clear releases it
    step(0, 8'h00, 1, 0);
    chk("ur_valid", bus.acc_valid, 0);
    chk("ur_hold", bus.acc_value, 8'h40 + 8'd39);
    chk("ur_flag", bus.underflow, 1);
    step(1, 8'h99, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("ur_pop", bus.acc_value, 8'h99);
    chk("ur_sticky", bus.underflow, 1);
    step(0, 8'h00, 0, 1);
    chk("ur_clear", bus.underflow, 0);

    // simultaneous push and pop on an empty buffer: no bypass
    step(1, 8'h5A, 1, 0);
    chk("nb_valid", bus.acc_valid, 0);
    chk("nb_under", bus.underflow, 1);
    chk("nb_count", bus.count, 1);
    step(0, 8'h00, 1, 0);
    chk("nb_pop", bus.acc_value, 8'h5A);

    // clear discards a coincident push
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
    chk("pre_clear_count", bus.count, 5);
    step(1, 8'h77, 0, 1);
    chk("clr_count", bus.count, 0);
    chk("clr_empty", bus.empty, 1);
    chk("clr_hold", bus.acc_value, 8'h5A);
    step(0, 8'h00, 1, 0);
    chk("clr_no77", bus.acc_valid, 0);

    // reset in the middle of traffic
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 1, 0);
    do_reset();
    chk("rst_underflow", bus.underflow, 0);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("post_rst_pop", bus.acc_value, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_register.md
Name: input_register

Overview:
- 32-entry x 8-bit receive buffer. It is the inbound counterpart of the CPU's output register: external logic pushes bytes in, and the CPU pops them into the accumulator.
- Entries are held in arrival order in a circular FIFO.
- The external side uses a valid/ready handshake. The CPU side uses a single-cycle read strobe with a registered result.
- Sits between the external input pins/peripheral and the accumulator load path.

Parameters:
- DATA_WIDTH, 8, width of each entry and of the accumulator path
- DEPTH, 32, number of entries; must be a power of two
- ADDR_WIDTH, 5, log2(DEPTH); pointer width

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ext_data  input  8  byte presented by the external producer
- ext_valid  input  1  producer asserts while ext_data is valid
- ext_ready  output  1  block can accept a byte this cycle
- read_enable  input  1  CPU pop strobe; one entry per cycle while high
- clear  input  1  synchronous flush of buffer contents, CPU-driven
- acc_value  output  8  popped byte to the accumulator; registered
- acc_valid  output  1  one-cycle pulse: acc_value updated this cycle
- count  output  6  number of stored entries, 0..32
- empty  output  1  count == 0
- full  output  1  count == 32
- underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset, synchronous, active-high, takes priority over everything:
  - wr_ptr=0, rd_ptr=0, count=0
  - acc_value=8'h00, acc_valid=0, underflow=0
  - Memory contents are not cleared.
  - Reset asserted mid-transfer drops any handshake in that cycle; no entry is written.
- ext_ready = !full, combinational from count.
- Push occurs when ext_valid && ext_ready:
  - mem[wr_ptr] <= ext_data
  - wr_ptr increments modulo DEPTH; it wraps 31 -> 0.
  - Data must hold while ext_valid=1 && ext_ready=0. The producer may not retract; the block does not check this.
- Pop occurs when read_enable && !empty, where empty is the value at the start of the cycle:
  - acc_value <= mem[rd_ptr] and acc_valid <= 1 on the same edge, so data is visible 1 cycle after the strobe.
  - rd_ptr increments modulo DEPTH.
- Empty read, i.e. read_enable && empty:
  - No pointer change, acc_value holds, acc_valid=0.
  - underflow <= 1, and it stays set until reset or clear.
- acc_valid is 0 in every cycle that does not follow a successful pop. acc_value otherwise holds its last value.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Simultaneous push and pop:
  - When non-empty and not full, both proceed; the pop returns the oldest entry.
  - When empty, only the push proceeds. There is no bypass: the new byte is readable from the next cycle.
  - When full, ext_ready=0, so only the pop proceeds. ext_ready rises the following cycle.
- Clear, one-cycle action, lower priority than reset and higher than push/pop in the same cycle:
  - wr_ptr=rd_ptr=0, count=0, underflow=0, acc_valid=0
  - acc_value holds.
  - A push coincident with clear is discarded.
- full and empty are derived from count, never from pointer equality alone.

Test Plan:
- Reset, then push 8'h11, 8'h22, 8'h33 on consecutive cycles with ext_valid=1 -> count=3. Three read_enable pulses -> acc_value 11, 22, 33, each with acc_valid=1 one cycle after its strobe; then empty=1.
- Push 32 bytes 8'h00..8'h1F -> full=1 and ext_ready=0. A 33rd byte 8'hAA held valid is not accepted. Pop once: acc_value=8'h00 and ext_ready=1 next cycle; 8'hAA is then accepted and count=32.
- Wrap-around: push and pop 40 bytes in an interleaved pattern -> output order exactly equals input order across the 31->0 pointer wrap, and count never exceeds 32.
- read_enable while empty -> acc_valid=0, acc_value unchanged, underflow=1. A later push and pop succeed normally while underflow stays 1. clear -> underflow=0.
- Empty buffer with push 8'h5A and read_enable in the same cycle -> no acc_valid that cycle+1, underflow=1, count=1. Next read_enable returns 8'h5A.
- With count=5, assert clear together with ext_valid=1 (data 8'h77) -> count=0, empty=1, and 8'h77 is not stored. Assert reset mid-stream -> all outputs at reset values the next cycle.
